midi_poly_synth: RTL and testbench
==================================

MIDI_POLY_SYNTH -- requirements
Module: midi_poly_synth

Interface
REQ-001 SHALL have parameter pVoices, default 4: number of voices; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter pAudioBitWidth, default 16: signed sample width per channel.
REQ-003 SHALL have parameter pPhaseWidth, default 24: phase accumulator width.
REQ-004 SHALL have parameter pMidiChannel, default 0: accepted MIDI channel, 0-15.
REQ-005 SHALL have port iCLK, input, 1 bit: the only clock; all logic SHALL be on its rising edge.
REQ-006 SHALL have port iRST, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port iMidiRd, input, 8 bits: received MIDI byte.
REQ-008 SHALL have port iMidiVd, input, 1 bit: one-cycle strobe marking iMidiRd valid.
REQ-009 SHALL have port iWaveSel, input, 2 bits: waveform select; 0 saw, 1 square, 2 triangle, 3 silence.
REQ-010 SHALL have port iSampleReq, input, 1 bit: one-cycle strobe requesting the next sample.
REQ-011 SHALL have port oAudioData, output, 2*pAudioBitWidth bits: {L,R}; L and R identical.
REQ-012 SHALL have port oAudioVd, output, 1 bit: one-cycle strobe marking oAudioData updated.
REQ-013 SHALL have port oVoiceActive, output, pVoices bits: per-voice active flags.
REQ-014 SHALL have port oOverrun, output, 1 bit: sticky flag; iSampleReq arrived while a mix was in progress.

Function
REQ-015 SHALL run the parser FSM with states IDLE, DATA1, DATA2.
- Status 0x90|ch or 0x80|ch with ch==pMidiChannel: store as running status, go to DATA1.
- Any other 0x80-0xEF status: running status set to ignore, go to DATA1.
- 0xF0-0xF7: running status cleared, go to IDLE.
- 0xF8-0xFF: no effect on state or running status.
REQ-016 SHALL treat a data byte (bit7=0) as follows.
- In IDLE with a valid running status: captured as note, FSM goes to DATA2.
- In DATA1: captured as note, FSM goes to DATA2.
- In DATA2: captured as velocity, event issued, FSM returns to IDLE.
- Data bytes under ignore or cleared status: discarded.
REQ-017 SHALL apply the voice-table update in the cycle after the velocity byte; note-on with velocity 0 SHALL be treated as note-off.
REQ-018 SHALL allocate voices on note-on in this priority order.
- A voice already holding the note: retriggered (phase := 0, velocity updated).
- Otherwise the lowest-index free voice.
- Otherwise the voice at the steal pointer, which then increments modulo pVoices.
REQ-019 SHALL, on note-off, free every voice holding that note; a note-off for an unheld note SHALL have no effect.
REQ-020 SHALL compute the phase increment as table[n mod 12] >> (10 - n/12).
- table holds round(f*2^pPhaseWidth/48000) for notes 120..131.
- Example: note 69 gives 4921317>>5 = 153791.
REQ-021 SHALL start a mix on iSampleReq while idle, processing one voice per cycle in index order.
- Active voice: phase += increment (wraps modulo 2^pPhaseWidth), then sample generated from the new phase.
- Inactive voice: contributes 0.
REQ-022 SHALL derive each sample from the top pAudioBitWidth phase bits.
- Saw: phase with MSB inverted.
- Square: +max when MSB=0, else -max-1.
- Triangle: folded saw, scaled by 2.
- Silence: 0.
REQ-023 SHALL scale each sample as (sample*velocity)>>>7 and accumulate in pAudioBitWidth+log2(pVoices) bits; the result SHALL be acc>>>log2(pVoices) with no saturation.
REQ-024 SHALL pulse oAudioVd and update oAudioData exactly pVoices+1 cycles after iSampleReq.
REQ-025 SHALL ignore iSampleReq during a mix and set oOverrun, which clears only on reset.
REQ-026 SHALL let voice-table events during a mix take effect immediately for voices not yet processed.

Reset
REQ-027 SHALL, on iRST low, asynchronously clear the following.
- Parser to IDLE, running status cleared.
- All voices inactive, phases 0, steal pointer 0.
- Mix FSM idle.
- oAudioData 0, oAudioVd 0, oVoiceActive 0, oOverrun 0.
REQ-028 SHALL discard an in-progress mix on reset, with no oAudioVd pulse.

Verification
REQ-029 Bytes 0x90,0x45,0x7F, iWaveSel=1, one iSampleReq -> oVoiceActive=0001 and, 5 cycles later, oAudioVd=1 with oAudioData=0x1FBF1FBF.
REQ-030 Five note-ons 60..64 -> voices 0-3 hold 60-63, note 64 steals voice 0, steal pointer becomes 1.
REQ-031 Running status: 0x90,0x3C,0x40,0x3E,0x40 -> two voices active, holding 60 and 62.
REQ-032 0x90,0x3C,0x00, or 0x80,0x3C,0x10, after note 60 is on -> that voice freed; 0xF8 between data bytes -> parse unaffected.
REQ-033 iSampleReq twice, 2 cycles apart -> a single oAudioVd pulse and oOverrun=1.
REQ-034 Reset asserted mid-mix -> all outputs 0 immediately, no oAudioVd pulse, channel-5 bytes ignored afterwards.

Source files
------------

// File: rtl/midi_poly_synth.sv
// midi_poly_synth: MIDI note-on/off parser driving a small bank of
// phase-accumulator voices, mixed one voice per cycle on sample request.
module midi_poly_synth #(
    parameter int pVoices        = 4,
    parameter int pAudioBitWidth = 16,
    parameter int pPhaseWidth    = 24,
    parameter int pMidiChannel   = 0
) (
    input  logic                        iCLK,
    input  logic                        iRST,
    input  logic [7:0]                  iMidiRd,
    input  logic                        iMidiVd,
    input  logic [1:0]                  iWaveSel,
    input  logic                        iSampleReq,
    output logic [2*pAudioBitWidth-1:0] oAudioData,
    output logic                        oAudioVd,
    output logic [pVoices-1:0]          oVoiceActive,
    output logic                        oOverrun
);
    localparam int AW   = pAudioBitWidth;
    localparam int PW   = pPhaseWidth;
    localparam int LG   = $clog2(pVoices);
    localparam int IW   = (pVoices > 1) ? LG : 1;
    localparam int ACCW = AW + LG;
    localparam logic [3:0]    CH   = 4'(pMidiChannel);
    localparam logic [IW-1:0] LAST = IW'(pVoices - 1);

    // running status: bit1 = note message for us, bit0 = note-on
    localparam logic [1:0] RS_NONE = 2'd0;
    localparam logic [1:0] RS_IGN  = 2'd1;
    localparam logic [1:0] RS_OFF  = 2'd2;
    localparam logic [1:0] RS_ON   = 2'd3;

    typedef enum logic [1:0] {IDLE, DATA1, DATA2} pstate_t;
    typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} mstate_t;

    pstate_t p_state, p_next;
    logic [1:0] rs, rs_d;
    logic [6:0] note_q;
    logic is_rt, is_sys, is_chan, is_data, ours;
    logic rs_we, note_we, ev_we;
    logic ev_valid, ev_on;
    logic [6:0] ev_note, ev_vel;

    always_comb begin
        is_data = ~iMidiRd[7];
        is_rt   = iMidiRd[7:3] == 5'b11111;
        is_sys  = iMidiRd[7:3] == 5'b11110;
        is_chan = iMidiRd[7] && (iMidiRd[7:4] != 4'hF);
        ours    = (iMidiRd[7:5] == 3'b100) && (iMidiRd[3:0] == CH);
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) p_state <= IDLE;
        else       p_state <= p_next;
    end

    always_comb begin
        p_next = p_state;
        if (iMidiVd) begin
            unique case (1'b1)
                is_rt:   p_next = p_state;
                is_sys:  p_next = IDLE;
                is_chan: p_next = DATA1;
                is_data: begin
                    case (p_state)
                        IDLE:    if (rs[1]) p_next = DATA2;
                        DATA1:   p_next = DATA2;
                        default: p_next = IDLE;
                    endcase
                end
            endcase
        end
    end

    always_comb begin
        rs_we   = iMidiVd && (is_sys || is_chan);
        rs_d    = is_sys ? RS_NONE : ours ? (iMidiRd[4] ? RS_ON : RS_OFF) : RS_IGN;
        note_we = iMidiVd && is_data &&
                  ((p_state == DATA1) || ((p_state == IDLE) && rs[1]));
        ev_we   = iMidiVd && is_data && (p_state == DATA2) && rs[1];
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            rs       <= RS_NONE;
            note_q   <= '0;
            ev_valid <= 1'b0;
            ev_on    <= 1'b0;
            ev_note  <= '0;
            ev_vel   <= '0;
        end else begin
            ev_valid <= ev_we;
            if (rs_we) rs <= rs_d;
            if (note_we) note_q <= iMidiRd[6:0];
            if (ev_we) begin
                ev_on   <= rs[0] && (iMidiRd[6:0] != 7'd0);
                ev_note <= note_q;
                ev_vel  <= iMidiRd[6:0];
            end
        end
    end

    // octave-10 increments for 24-bit phase, rescaled to PW and shifted down
    function automatic logic [PW-1:0] note_inc(input logic [6:0] n);
        logic [3:0]  semi;
        logic [3:0]  oct;
        logic [63:0] t;
        semi = 4'(n % 7'd12);
        oct  = 4'(n / 7'd12);
        case (semi)
            4'd0:    t = 64'd2926232;
            4'd1:    t = 64'd3100235;
            4'd2:    t = 64'd3284585;
            4'd3:    t = 64'd3479896;
            4'd4:    t = 64'd3686822;
            4'd5:    t = 64'd3906052;
            4'd6:    t = 64'd4138318;
            4'd7:    t = 64'd4384395;
            4'd8:    t = 64'd4645104;
            4'd9:    t = 64'd4921317;
            4'd10:   t = 64'd5213953;
            default: t = 64'd5523991;
        endcase
        t = (t << PW) >> 24;
        t = t >> (4'd10 - oct);
        return t[PW-1:0];
    endfunction

    logic [pVoices-1:0] active;
    logic [6:0]         v_note  [pVoices];
    logic [6:0]         v_vel   [pVoices];
    logic [PW-1:0]      v_phase [pVoices];
    logic [IW-1:0]      steal, alloc, hit_idx, free_idx;
    logic               hit, free_any;

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = pVoices - 1; i >= 0; i--) begin
            if (active[i] && (v_note[i] == ev_note)) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
            if (!active[i]) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
        end
        alloc = hit ? hit_idx : free_any ? free_idx : steal;
    end

    mstate_t m_state, m_next;
    logic [IW-1:0] idx;
    logic mix_start, mix_step, mix_emit;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) m_state <= M_IDLE;
        else       m_state <= m_next;
    end

    always_comb begin
        m_next = m_state;
        case (m_state)
            M_IDLE:  if (iSampleReq) m_next = M_RUN;
            M_RUN:   if (idx == LAST) m_next = M_DONE;
            default: m_next = M_IDLE;
        endcase
    end

    always_comb begin
        mix_start = (m_state == M_IDLE) && iSampleReq;
        mix_step  = (m_state == M_RUN);
        mix_emit  = (m_state == M_DONE);
    end

    logic [PW-1:0]          cur_inc, new_phase;
    logic [AW-1:0]          top;
    logic [AW-2:0]          fold;
    logic signed [AW-1:0]   smp, mix_out;
    logic signed [AW+7:0]   prod;
    logic signed [ACCW-1:0] contrib, acc;

    always_comb begin
        cur_inc   = note_inc(v_note[idx]);
        new_phase = v_phase[idx] + cur_inc;
        top       = new_phase[PW-1 -: AW];
        fold      = top[AW-1] ? ~top[AW-2:0] : top[AW-2:0];
        case (iWaveSel)
            2'd0:    smp = {~top[AW-1], top[AW-2:0]};
            2'd1:    smp = top[AW-1] ? {1'b1, {(AW-1){1'b0}}}
                                     : {1'b0, {(AW-1){1'b1}}};
            2'd2:    smp = {~fold[AW-2], fold[AW-3:0], 1'b0};
            default: smp = '0;
        endcase
        prod    = (AW+8)'(smp) * $signed((AW+8)'({1'b0, v_vel[idx]}));
        contrib = active[idx] ? ACCW'(prod >>> 7) : '0;
        mix_out = AW'(acc >>> LG);
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            idx        <= '0;
            acc        <= '0;
            oAudioData <= '0;
            oAudioVd   <= 1'b0;
            oOverrun   <= 1'b0;
        end else begin
            if (mix_start) begin
                idx <= '0;
                acc <= '0;
            end else if (mix_step) begin
                acc <= acc + contrib;
                idx <= (idx == LAST) ? '0 : idx + IW'(1);
            end
            oAudioVd <= mix_emit;
            if (mix_emit) oAudioData <= {mix_out, mix_out};
            if (iSampleReq && (m_state != M_IDLE)) oOverrun <= 1'b1;
        end
    end

    // a note event on the voice being mixed this cycle overrides its phase step
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            active <= '0;
            steal  <= '0;
            for (int i = 0; i < pVoices; i++) begin
                v_note[i]  <= '0;
                v_vel[i]   <= '0;
                v_phase[i] <= '0;
            end
        end else begin
            for (int i = 0; i < pVoices; i++) begin
                if (mix_step && (idx == IW'(i)) && active[i])
                    v_phase[i] <= new_phase;
                if (ev_valid && ev_on && (alloc == IW'(i))) begin
                    active[i]  <= 1'b1;
                    v_note[i]  <= ev_note;
                    v_vel[i]   <= ev_vel;
                    v_phase[i] <= '0;
                end
                if (ev_valid && !ev_on && active[i] && (v_note[i] == ev_note))
                    active[i] <= 1'b0;
            end
            if (ev_valid && ev_on && !hit && !free_any)
                steal <= (steal == LAST) ? '0 : steal + IW'(1);
        end
    end

    assign oVoiceActive = active;

endmodule

// File: tb/tb_midi_poly_synth.sv
// Directed bench for midi_poly_synth: voice model plus a queue of
// expected mixes popped on each oAudioVd pulse.
module tb_midi_poly_synth;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  midi_rd;
    logic        midi_vd;
    logic [1:0]  wave_sel;
    logic        sreq;
    logic [31:0] audio;
    logic        audio_vd;
    logic [3:0]  voice_active;
    logic        overrun;

    midi_poly_synth dut (
        .iCLK        (clk),
        .iRST        (rst_n),
        .iMidiRd     (midi_rd),
        .iMidiVd     (midi_vd),
        .iWaveSel    (wave_sel),
        .iSampleReq  (sreq),
        .oAudioData  (audio),
        .oAudioVd    (audio_vd),
        .oVoiceActive(voice_active),
        .oOverrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] sb[$];

    int unsigned tbl [12] = '{2926232, 3100235, 3284585, 3479896,
                              3686822, 3906052, 4138318, 4384395,
                              4645104, 4921317, 5213953, 5523991};
    bit          ba [4];
    int          bn [4];
    int          bv [4];
    int unsigned bp [4];
    int          steal;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            ba[i] = 0; bn[i] = 0; bv[i] = 0; bp[i] = 0;
        end
        steal = 0;
    endtask

    task automatic model_off(input int n);
        for (int i = 0; i < 4; i++)
            if (ba[i] && bn[i] == n) ba[i] = 0;
    endtask

    task automatic model_on(input int n, input int v);
        int sel;
        if (v == 0) begin
            model_off(n);
            return;
        end
        sel = -1;
        for (int i = 0; i < 4; i++)
            if (sel < 0 && ba[i] && bn[i] == n) sel = i;
        for (int i = 0; i < 4; i++)
            if (sel < 0 && !ba[i]) sel = i;
        if (sel < 0) begin
            sel = steal;
            steal = (steal + 1) % 4;
        end
        ba[sel] = 1; bn[sel] = n; bv[sel] = v; bp[sel] = 0;
    endtask

    function automatic logic [3:0] model_active();
        logic [3:0] a;
        for (int i = 0; i < 4; i++) a[i] = ba[i];
        return a;
    endfunction

    function automatic int wave(input int unsigned ph, input logic [1:0] ws);
        int top, fold;
        top = int'((ph >> 8) & 32'hFFFF);
        fold = (top >= 32768) ? 65535 - top : top;
        case (ws)
            2'd0:    return top - 32768;
            2'd1:    return (top < 32768) ? 32767 : -32768;
            2'd2:    return 2 * fold - 32768;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_mix();
        int acc, r, s;
        int unsigned inc;
        logic [15:0] r16;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            if (ba[i]) begin
                inc = tbl[bn[i] % 12] >> (10 - bn[i] / 12);
                bp[i] = (bp[i] + inc) & 32'hFFFFFF;
                s = wave(bp[i], wave_sel);
                acc += (s * bv[i]) >>> 7;
            end
        end
        r = acc >>> 2;
        r16 = r[15:0];
        return {r16, r16};
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        midi_rd = b;
        midi_vd = 1'b1;
        @(negedge clk);
        midi_vd = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic msg(input logic [7:0] st, input int n, input int v);
        send(st);
        send(8'(n));
        send(8'(v));
        if (st == 8'h90) model_on(n, v);
        else if (st == 8'h80) model_off(n);
        settle();
    endtask

    task automatic sample_req(input string tag);
        int lat;
        sb.push_back(model_mix());
        @(negedge clk);
        sreq = 1'b1;
        @(negedge clk);
        sreq = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (audio_vd) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_lat"}, lat, 5);
        if (lat != 0) chk({tag, "_data"}, audio, sb.pop_front());
        else void'(sb.pop_front());
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        rst_n = 1'b0;
        midi_rd = '0;
        midi_vd = 1'b0;
        wave_sel = 2'd1;
        sreq = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", audio, 0);
        chk("rst_vd", audio_vd, 0);
        chk("rst_active", voice_active, 0);
        chk("rst_ovr", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;

        msg(8'h90, 8'h45, 8'h7F);
        chk("on69", voice_active, 4'b0001);
        sample_req("sq69");
        chk("sq69_lit", audio, 32'h1FBF1FBF);
        wave_sel = 2'd0;
        sample_req("saw69");
        msg(8'h80, 8'h45, 8'h00);
        chk("off69", voice_active, model_active());

        send(8'h90); send(8'h3C); send(8'h40); send(8'h3E); send(8'h40);
        model_on(60, 64);
        model_on(62, 64);
        settle();
        chk("runstat", voice_active, 4'b0011);
        msg(8'h80, 8'h30, 8'h10);
        chk("off_unheld", voice_active, 4'b0011);
        msg(8'h90, 8'h3C, 8'h00);
        chk("on_vel0", voice_active, 4'b0010);
        msg(8'h80, 8'h3E, 8'h10);
        chk("off62", voice_active, 4'b0000);

        send(8'h90); send(8'h3C); send(8'hF8); send(8'h50);
        model_on(60, 80);
        settle();
        chk("rt_between", voice_active, 4'b0001);
        wave_sel = 2'd2;
        sample_req("tri60a");
        sample_req("tri60b");
        msg(8'h80, 8'h3C, 8'h00);

        for (int n = 60; n <= 64; n++) msg(8'h90, n, 100);
        chk("steal_full", voice_active, 4'b1111);
        wave_sel = 2'd0;
        sample_req("saw4");
        msg(8'h80, 64, 0);
        chk("steal_v0", voice_active, 4'b1110);
        msg(8'h90, 65, 90);
        chk("refill_v0", voice_active, 4'b1111);
        msg(8'h90, 66, 70);
        msg(8'h80, 66, 0);
        chk("steal_ptr1", voice_active, 4'b1101);
        wave_sel = 2'd1;
        sample_req("sq3");

        sb.push_back(model_mix());
        @(negedge clk); sreq = 1'b1;
        @(negedge clk); sreq = 1'b0;
        @(negedge clk); sreq = 1'b1;
        @(negedge clk); sreq = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (audio_vd) begin
                pulses++;
                if (sb.size() > 0) chk("ovr_data", audio, sb.pop_front());
            end
        end
        chk("ovr_pulses", pulses, 1);
        chk("ovr_flag", overrun, 1);

        @(negedge clk); sreq = 1'b1;
        @(negedge clk); sreq = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_data", audio, 0);
        chk("mid_vd", audio_vd, 0);
        chk("mid_active", voice_active, 0);
        chk("mid_ovr", overrun, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (audio_vd) pulses++;
        end
        chk("mid_nopulse", pulses, 0);

        msg(8'h95, 8'h40, 8'h40);
        chk("ch5_ign", voice_active, 4'b0000);
        msg(8'h90, 8'h40, 8'h40);
        chk("ch0_on", voice_active, 4'b0001);
        send(8'hF0); send(8'h41); send(8'h42);
        settle();
        chk("sysex_clr", voice_active, 4'b0001);
        send(8'hB0); send(8'h41); send(8'h42);
        settle();
        chk("cc_ign", voice_active, 4'b0001);
        wave_sel = 2'd0;
        sample_req("saw64");
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
